// File: rtl/tfs_tx_if.sv
// Word handshake between a data source and the tfs_tx UART transmitter.
// A word transfers on a rising clk edge when data_valid and data_ready are both high;
// the sink samples data_in only on that edge, and the source keeps data_in stable while data_valid is high.
interface tfs_tx_if;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/tfs_tx.sv
// Transmits each accepted 16-bit word as two 8N1 UART bytes, low byte first, LSB first.
// All outputs are registered. fsm_state exposes the controller state for debug.
module tfs_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    tfs_tx_if.slave    link,
    output logic       tx,
    output logic       busy,
    output logic       byte_cnt,
    output logic       word_done,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [7:0]       hi_byte;
    logic             period_end;

    assign period_end = (cnt == LAST);
    assign fsm_state  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            bit_idx         <= '0;
            shift           <= '0;
            hi_byte         <= '0;
            tx              <= 1'b1;
            link.data_ready <= 1'b0;
            busy            <= 1'b0;
            byte_cnt        <= 1'b0;
            word_done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (link.data_valid && link.data_ready) begin
                        shift           <= link.data_in[7:0];
                        hi_byte         <= link.data_in[15:8];
                        byte_cnt        <= 1'b0;
                        busy            <= 1'b1;
                        link.data_ready <= 1'b0;
                        tx              <= 1'b0;
                        state           <= START;
                    end else begin
                        link.data_ready <= 1'b1;
                        busy            <= 1'b0;
                        tx              <= 1'b1;
                    end
                end

                START: begin
                    if (period_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (period_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // shift[1] is the next bit once this shift lands
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (period_end) begin
                        cnt <= '0;
                        if (!byte_cnt) begin
                            shift    <= hi_byte;
                            byte_cnt <= 1'b1;
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
                            word_done       <= 1'b0;
                            busy            <= 1'b0;
                            link.data_ready <= 1'b1;
                            byte_cnt        <= 1'b0;
                            state           <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        // Raised one edge early so the pulse coincides with the final stop-bit cycle.
                        if (byte_cnt && (cnt == PRE_LAST)) begin
                            word_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tfs_tx.sv
// Bench for tfs_tx: a line decoder and a word_done monitor check against an expected queue
// filled from a cycle-level model of accept timing.
module tb_tfs_tx;
    localparam int CPB = 4;
    localparam int CW  = 3;
    localparam int W   = 41;   // {start_cycle[31:0], byte_idx, byte[7:0]}

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       tx;
    logic       busy;
    logic       byte_cnt;
    logic       word_done;
    logic [1:0] fsm_state;

    tfs_tx_if link();

    tfs_tx #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .link     (link),
        .tx       (tx),
        .busy     (busy),
        .byte_cnt (byte_cnt),
        .word_done(word_done),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [W-1:0] exp_q[$];
    int           done_q[$];
    int           free_at     = 1 << 30;
    int           busy_from   = 1;
    int           busy_to     = 0;
    int           acc_cnt     = 0;
    int           frames_seen = 0;
    bit           exp_ready;
    bit           exp_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: a word is accepted when the source is valid and the transmitter has
    // been free since one cycle after the previous word_done; a word occupies 20 bit periods.
    always @(negedge clk) begin
        if (!rst_n) begin
            free_at   = cyc + 2;
            busy_from = 1;
            busy_to   = 0;
            exp_q.delete();
            done_q.delete();
        end else begin
            exp_ready = (cyc >= free_at);
            exp_busy  = (cyc >= busy_from) && (cyc <= busy_to);
            chk("data_ready", link.data_ready, exp_ready);
            chk("busy", busy, exp_busy);
            if (!exp_busy) begin
                chk("idle_tx", tx, 1'b1);
                chk("idle_byte_cnt", byte_cnt, 1'b0);
            end
            if (exp_ready && link.data_valid) begin
                exp_q.push_back({32'(cyc + 1), 1'b0, link.data_in[7:0]});
                exp_q.push_back({32'(cyc + 1 + 10 * CPB), 1'b1, link.data_in[15:8]});
                done_q.push_back(cyc + 20 * CPB);
                free_at   = cyc + 20 * CPB + 1;
                busy_from = cyc + 1;
                busy_to   = cyc + 20 * CPB;
                acc_cnt++;
            end
        end
    end

    // ---------------- line decoder ----------------
    task automatic decode_frame();
        int           s;
        bit           have;
        logic [W-1:0] e;
        logic [7:0]   b;
        s    = cyc;
        have = (exp_q.size() != 0);
        frames_seen++;
        chk("frame_expected", have, 1'b1);
        e = '0;
        if (have) e = exp_q.pop_front();
        for (int k = 0; k < CPB / 2; k++) begin
            @(negedge clk);
            if (!rst_n) return;
        end
        chk("start_bit", tx, 1'b0);
        if (have) begin
            chk("frame_start_cycle", 64'(s), 64'(e[W-1:9]));
            chk("byte_cnt", byte_cnt, e[8]);
        end
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < CPB; k++) begin
                @(negedge clk);
                if (!rst_n) return;
            end
            b[i] = tx;
        end
        for (int k = 0; k < CPB; k++) begin
            @(negedge clk);
            if (!rst_n) return;
        end
        chk("stop_bit", tx, 1'b1);
        if (have) chk("data_byte", b, e[7:0]);
        for (int k = 0; k < CPB - CPB / 2 - 1; k++) begin
            @(negedge clk);
            if (!rst_n) return;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) decode_frame();
        end
    end

    // ---------------- word_done monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (done_q.size() != 0 && cyc > done_q[0]) begin
                chk("word_done_missing", 64'(cyc), 64'(done_q[0]));
                void'(done_q.pop_front());
            end
            if (word_done) begin
                chk("word_done_expected", done_q.size() != 0, 1'b1);
                if (done_q.size() != 0) begin
                    chk("word_done_cycle", 64'(cyc), 64'(done_q[0]));
                    void'(done_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [15:0] d, input bit hold);
        int c0;
        int n;
        c0 = acc_cnt;
        n  = 0;
        @(posedge clk);
        #1;
        link.data_in    = d;
        link.data_valid = 1'b1;
        while (acc_cnt == c0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("accept_in_time", acc_cnt != c0, 1'b1);
        #1;
        if (!hold) link.data_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0 || cyc < free_at) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_in_time", n < 2000, 1'b1);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx"}, tx, 1'b1);
        chk({tag, "_ready"}, link.data_ready, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_byte_cnt"}, byte_cnt, 1'b0);
        chk({tag, "_word_done"}, word_done, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] d;
        int          junk;
        link.data_in    = '0;
        link.data_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle line after reset
        repeat (1000) @(posedge clk);
        chk("idle_frames", 64'(frames_seen), 64'd0);

        // Single word
        send(16'hA53C, 1'b0);
        drain();

        // Back-to-back with valid held
        send(16'h0001, 1'b1);
        send(16'hFFFF, 1'b0);
        drain();

        // Valid pulse while busy is ignored
        send(16'h00FF, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        link.data_in    = 16'h1234;
        link.data_valid = 1'b1;
        @(posedge clk);
        #1 link.data_valid = 1'b0;
        drain();

        // Reset during data bit 3 of the high byte (that bit is 0 so tx=1 is a real change)
        send(16'h37C4, 1'b0);
        repeat (14 * CPB + 1) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midword_reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        send(16'h5A5A, 1'b0);
        drain();

        // data_in changes after handshake
        send(16'hC3C3, 1'b0);
        link.data_in = 16'h0000;
        drain();

        // Randomized words with data_in noise and valid pulses while busy
        for (int w = 0; w < 12; w++) begin
            d = 16'($urandom);
            send(d, 1'b0);
            junk = $urandom_range(0, 60);
            for (int k = 0; k < junk; k++) begin
                @(posedge clk);
                #1;
                link.data_in    = 16'($urandom);
                link.data_valid = ($urandom_range(0, 3) == 0);
            end
            link.data_valid = 1'b0;
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();

        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        chk("done_q_empty", 64'(done_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit, %0d/%0d passed so far", pass_cnt, chk_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
